// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types and constants
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  // Prefix bytes, exported for downstream scan-code decode only
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// rtl/ps2_receiver_if.sv - received-byte and error-pulse bundle
interface ps2_receiver_if;
  import ps2_pkg::*;

  logic [PS2_DATA_BITS-1:0] received_data;
  logic                     received_data_en;
  logic                     frame_err;
  logic                     parity_err;

  modport master (output received_data, received_data_en, frame_err, parity_err);
  modport slave  (input  received_data, received_data_en, frame_err, parity_err);

endinterface

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - synchronizers, ps2clk glitch filter and fall-pulse generator
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk,
  input  logic ps2data,
  output logic fall,
  output logic data_sync
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;
  logic          fall_q;

  // The filtered level flips only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      cnt      <= '0;
      fall_q   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2data};
      fall_q   <= 1'b0;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt   <= clk_sync[1];
        cnt    <= '0;
        fall_q <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign fall      = fall_q;
  assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard frame receiver; PS2_PARITY_CHECK_EN enables parity rejection
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ps2clk,
  input  logic           ps2data,
  ps2_receiver_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall;
  logic din;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .fall      (fall),
    .data_sync (din)
  );

  ps2_state_e               state_q, state_d;
  logic [2:0]               bit_q, bit_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [PS2_DATA_BITS-1:0] data_q, data_d;
  logic                     en_q, en_d;
  logic                     ferr_q, ferr_d;
  logic                     perr_q, perr_d;
`ifdef PS2_PARITY_CHECK_EN
  logic                     par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      timer_q <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    timer_d = '0;
    data_d  = data_q;
    en_d    = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE && !fall) begin
      timer_d = timer_q + 1'b1;
    end
    // A fall pulse in the expiry cycle takes precedence over the timeout
    if (state_q != IDLE && !fall && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      timer_d = '0;
      ferr_d  = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!din) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            ferr_d  = 1'b1;
          end
        end
        DATA: begin
          shift_d = {din, shift_q[PS2_DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = din;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!din) begin
            ferr_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
`endif
          end else begin
            en_d   = 1'b1;
            data_d = shift_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx.received_data    = data_q;
  assign rx.received_data_en = en_q;
  assign rx.frame_err        = ferr_q;
  assign rx.parity_err       = perr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - self-checking bench for ps2_receiver
module tb_ps2_receiver;
  import ps2_pkg::*;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 1000;
  localparam int LAT        = FILTER_LEN + 3;
  localparam logic [1:0] K_DATA = 2'd0, K_FRAME = 2'd1, K_PAR = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   fall_cyc = 0;
  int   pulse_cyc = -1;
  logic [7:0] model_data = 8'h00;
  exp_t exp_q[$];

  ps2_receiver_if rx_if ();

  ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2clk  (ps2clk),
    .ps2data (ps2data),
    .rx      (rx_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Outcome of a complete frame from the protocol rules alone
  function automatic logic [1:0] outcome(input logic [7:0] d, input logic p, input logic s);
    if (!s) return K_FRAME;
    if (($countones({d, p}) % 2) == 1) return K_DATA;
`ifdef PS2_PARITY_CHECK_EN
    return K_PAR;
`else
    return K_DATA;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_data", {24'h0, rx_if.received_data}, 32'h0);
      chk("rst_pulses", {29'h0, rx_if.received_data_en, rx_if.frame_err, rx_if.parity_err}, 32'h0);
    end else begin
      if (rx_if.received_data_en || rx_if.frame_err || rx_if.parity_err) begin
        pulse_cyc = cyc;
        chk("one_hot_pulse", 32'(rx_if.received_data_en + rx_if.frame_err + rx_if.parity_err), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'h0, rx_if.received_data_en, rx_if.frame_err, rx_if.parity_err}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_en",   {31'h0, rx_if.received_data_en}, {31'h0, e.kind == K_DATA});
          chk("pulse_kind_ferr", {31'h0, rx_if.frame_err},        {31'h0, e.kind == K_FRAME});
          chk("pulse_kind_perr", {31'h0, rx_if.parity_err},       {31'h0, e.kind == K_PAR});
          if (e.kind == K_DATA) model_data = e.data;
        end
      end
      chk("received_data", {24'h0, rx_if.received_data}, {24'h0, model_data});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2data = b;
    wait_cyc(10);
    ps2clk   = 1'b0;
    fall_cyc = cyc;
    wait_cyc(20);
    ps2clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
  endtask

  task automatic send_frame(input string name, input logic [7:0] d, input logic p, input logic s);
    logic [1:0] k;
    k = outcome(d, p, s);
    exp_q.push_back('{kind: k, data: d});
    pulse_cyc = -1;
    send_bits(d, 8);
    ps2_bit(p);
    ps2_bit(s);
    wait_cyc(40);
    chk({name, "_latency"}, 32'(pulse_cyc - fall_cyc), 32'(LAT));
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    chk("reset_data", {24'h0, rx_if.received_data}, 32'h0);
    chk("reset_en", {31'h0, rx_if.received_data_en}, 32'h0);
    wait_cyc(5);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_cyc(20);

    send_frame("f_1c", 8'h1C, 1'b0, 1'b1);
    chk("lit_1c", {24'h0, rx_if.received_data}, 32'h1C);

    send_frame("f_f0", PS2_BREAK, 1'b1, 1'b1);
    chk("lit_f0", {24'h0, rx_if.received_data}, 32'hF0);
    send_frame("f_1c_b", 8'h1C, 1'b0, 1'b1);
    send_frame("f_e0", PS2_EXT, 1'b0, 1'b1);
    chk("lit_e0", {24'h0, rx_if.received_data}, 32'hE0);
    send_frame("f_1c_c", 8'h1C, 1'b0, 1'b1);

    send_frame("f_1c_badpar", 8'h1C, 1'b1, 1'b1);
    chk("lit_after_badpar", {24'h0, rx_if.received_data}, 32'h1C);

    send_frame("f_15_badstop", 8'h15, 1'b0, 1'b0);
    chk("lit_after_badstop", {24'h0, rx_if.received_data}, 32'h1C);

    // lone fall with data high: bad start bit
    exp_q.push_back('{kind: K_FRAME, data: 8'h00});
    pulse_cyc = -1;
    ps2_bit(1'b1);
    wait_cyc(40);
    chk("badstart_latency", 32'(pulse_cyc - fall_cyc), 32'(LAT));
    chk("badstart_drain", 32'(exp_q.size()), 32'd0);

    // ps2clk low for one sample short of FILTER_LEN is rejected as a glitch
    @(negedge clk);
    ps2data = 1'b1;
    ps2clk  = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2clk = 1'b1;
    wait_cyc(40);
    chk("glitch_no_pulse", 32'(exp_q.size()), 32'd0);
    send_frame("f_29_after_glitch", 8'h29, 1'b0, 1'b1);

    exp_q.push_back('{kind: K_FRAME, data: 8'h00});
    send_bits(8'h15, 4);
    wait_cyc(TIMEOUT + 500);
    chk("timeout_drain", 32'(exp_q.size()), 32'd0);
    send_frame("f_15_after_to", 8'h15, 1'b0, 1'b1);
    chk("lit_15", {24'h0, rx_if.received_data}, 32'h15);

    send_bits(8'h33, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", {24'h0, rx_if.received_data}, 32'h0);
    chk("midrst_pulses", {29'h0, rx_if.received_data_en, rx_if.frame_err, rx_if.parity_err}, 32'h0);
    model_data = 8'h00;
    exp_q.delete();
    wait_cyc(3);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_cyc(20);
    send_frame("f_29_after_rst", 8'h29, 1'b0, 1'b1);
    chk("lit_29", {24'h0, rx_if.received_data}, 32'h29);

    wait_cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
